count_mod_bcd: RTL and testbench

COUNT_MOD_BCD -- requirements
Module: count_mod_bcd

---
 rtl/count_mod_bcd.sv | 102 ++++++++++
 tb/tb_count_mod_bcd.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/count_mod_bcd.sv
// Up/down two-digit BCD counter with a programmable modulus, a checked parallel load,
// and a combinational carry/borrow output intended to drive the enable of a cascaded stage.
module count_mod_bcd #(
   parameter int MOD     = 60,
   parameter bit TENS_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] ld_ones,
   input  logic [3:0] ld_tens,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       co,
   output logic       ld_err
);

   localparam logic [7:0] MAX_V    = 8'(MOD - 1);
   localparam logic [3:0] MAX_ONES = 4'((MOD - 1) % 10);
   localparam logic [3:0] MAX_TENS = 4'((MOD - 1) / 10);

   logic [3:0] r_ones, r_tens;
   logic       r_ld_err;

   logic [3:0] w_ones_nxt, w_tens_nxt;
   logic       w_ld_err_nxt;
   logic [3:0] w_ld_tens;
   logic [7:0] w_ld_val;
   logic       w_ld_ok;
   logic       w_at_max, w_at_zero;

   // Without a tens digit the loaded tens value is ignored, so treat it as zero.
   assign w_ld_tens = TENS_EN ? ld_tens : 4'd0;
   assign w_ld_val  = ({4'd0, w_ld_tens} * 8'd10) + {4'd0, ld_ones};
   assign w_ld_ok   = (ld_ones <= 4'd9) && (w_ld_tens <= 4'd9) && (w_ld_val <= MAX_V);

   assign w_at_max  = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
   assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

   // A pending load suppresses the carry, since the load wins over the count step.
   assign co = en & ~load & (up ? w_at_max : w_at_zero);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_ones_nxt   = r_ones;
      w_tens_nxt   = r_tens;
      w_ld_err_nxt = 1'b0;
      if (load) begin
         if (w_ld_ok) begin
            w_ones_nxt = ld_ones;
            w_tens_nxt = w_ld_tens;
         end else begin
            w_ld_err_nxt = 1'b1;
         end
      end else if (en) begin
         if (up) begin
            if (w_at_max) begin
               w_ones_nxt = 4'd0;
               w_tens_nxt = 4'd0;
            end else if (r_ones == 4'd9) begin
               w_ones_nxt = 4'd0;
               w_tens_nxt = r_tens + 4'd1;
            end else begin
               w_ones_nxt = r_ones + 4'd1;
            end
         end else begin
            if (w_at_zero) begin
               w_ones_nxt = MAX_ONES;
               w_tens_nxt = MAX_TENS;
            end else if (r_ones == 4'd0) begin
               w_ones_nxt = 4'd9;
               w_tens_nxt = r_tens - 4'd1;
            end else begin
               w_ones_nxt = r_ones - 4'd1;
            end
         end
      end
      if (!TENS_EN) begin
         w_tens_nxt = 4'd0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ones   <= 4'd0;
         r_tens   <= 4'd0;
         r_ld_err <= 1'b0;
      end else begin
         r_ones   <= w_ones_nxt;
         r_tens   <= w_tens_nxt;
         r_ld_err <= w_ld_err_nxt;
      end
   end

   assign ones   = r_ones;
   assign tens   = r_tens;
   assign ld_err = r_ld_err;

endmodule

// File: tb/tb_count_mod_bcd.sv
// Bench for count_mod_bcd: a MOD=60 counter cascaded into a MOD=24 counter, checked every
// cycle against an integer-value model, plus directed literal checks of key values.
module tb_count_mod_bcd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] ld_ones = 4'd0;
   logic [3:0] ld_tens = 4'd0;

   logic [3:0] lo_ones, lo_tens, hi_ones, hi_tens;
   logic       lo_co, hi_co, lo_err, hi_err;

   int n_vec = 0;
   int n_bad = 0;
   bit running = 1'b1;
   bit cnt_en = 1'b0;
   int hi_co_pulses = 0;

   // Model state kept as plain integer values.
   int m_v = 0;
   int m_hi = 0;
   bit m_err = 1'b0;

   count_mod_bcd #(.MOD(60), .TENS_EN(1'b1)) u_lo (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .ld_ones(ld_ones), .ld_tens(ld_tens),
      .ones(lo_ones), .tens(lo_tens), .co(lo_co), .ld_err(lo_err)
   );

   count_mod_bcd #(.MOD(24), .TENS_EN(1'b1)) u_hi (
      .clk(clk), .rst(rst), .en(lo_co), .up(up), .load(1'b0),
      .ld_ones(4'd0), .ld_tens(4'd0),
      .ones(hi_ones), .tens(hi_tens), .co(hi_co), .ld_err(hi_err)
   );

   always #5 clk = ~clk;

   function automatic bit ld_valid();
      return (ld_ones <= 4'd9) && (ld_tens <= 4'd9) && (10 * int'(ld_tens) + int'(ld_ones) <= 59);
   endfunction

   function automatic bit m_lo_co();
      return en && !load && (m_v == (up ? 59 : 0));
   endfunction

   function automatic bit m_hi_co();
      return m_lo_co() && (m_hi == (up ? 23 : 0));
   endfunction

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_v   <= 0;
         m_hi  <= 0;
         m_err <= 1'b0;
      end else begin
         m_err <= load && !ld_valid();
         if (load) begin
            if (ld_valid()) m_v <= 10 * int'(ld_tens) + int'(ld_ones);
         end else if (en) begin
            m_v <= up ? (m_v + 1) % 60 : (m_v + 59) % 60;
         end
         if (m_lo_co()) m_hi <= up ? (m_hi + 1) % 24 : (m_hi + 23) % 24;
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (running) begin
         check("lo_state", {6'd0, lo_tens, lo_ones, lo_co, lo_err},
               {6'd0, bcd(m_v), m_lo_co(), m_err});
         check("hi_state", {7'd0, hi_tens, hi_ones, hi_co},
               {7'd0, bcd(m_hi), m_hi_co()});
         if (cnt_en && hi_co) hi_co_pulses++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      // Reset, then count up 59 steps to the terminal value and wrap.
      tick(2);
      check("rst_state", {lo_tens, lo_ones, lo_err}, 9'h000);
      rst = 1'b0;
      en  = 1'b1;
      tick(59);
      check("up_59", {lo_tens, lo_ones}, 8'h59);
      check("up_59_co", lo_co, 1'b1);
      tick(1);
      check("wrap_00", {lo_tens, lo_ones}, 8'h00);
      check("wrap_00_co", lo_co, 1'b0);

      // co during reset: low with up=1, terminal with up=0.
      rst = 1'b1;
      #1;
      check("rst_up_co", lo_co, 1'b0);
      up = 1'b0;
      #1;
      check("rst_dn_co", lo_co, 1'b1);
      tick(1);
      rst = 1'b0;
      check("dn_00_co", lo_co, 1'b1);
      tick(1);
      check("dn_59", {lo_tens, lo_ones}, 8'h59);
      tick(9);
      check("dn_50", {lo_tens, lo_ones}, 8'h50);
      tick(1);
      check("dn_49", {lo_tens, lo_ones}, 8'h49);

      // Loads: valid, out-of-range value, out-of-range digit.
      en = 1'b0;
      load = 1'b1; ld_tens = 4'd4; ld_ones = 4'd7;
      tick(1);
      load = 1'b0;
      check("ld_47", {lo_tens, lo_ones, lo_err}, 9'h08E);
      load = 1'b1; ld_tens = 4'd6; ld_ones = 4'd0;
      tick(1);
      load = 1'b0;
      check("ld_60_rej", {lo_tens, lo_ones, lo_err}, 9'h08F);
      tick(1);
      check("ld_err_clr", lo_err, 1'b0);
      load = 1'b1; ld_tens = 4'd3; ld_ones = 4'd12;
      tick(1);
      check("ld_3_12_rej", {lo_tens, lo_ones, lo_err}, 9'h08F);
      ld_tens = 4'd5; ld_ones = 4'd9;
      tick(1);
      load = 1'b0;
      check("ld_59", {lo_tens, lo_ones, lo_err}, 9'h0B2);

      // Load wins over a wrapping count; en=0 holds with co low.
      en = 1'b1; up = 1'b1; load = 1'b1; ld_tens = 4'd1; ld_ones = 4'd2;
      #1;
      check("ld_pri_co", lo_co, 1'b0);
      tick(1);
      load = 1'b0; en = 1'b0;
      check("ld_pri_12", {lo_tens, lo_ones}, 8'h12);
      tick(3);
      check("hold_12", {lo_tens, lo_ones, lo_co}, 9'h024);

      // Asynchronous reset between edges at 33, with an invalid load pending.
      load = 1'b1; ld_tens = 4'd3; ld_ones = 4'd3;
      tick(1);
      check("ld_33", {lo_tens, lo_ones}, 8'h33);
      ld_tens = 4'd9; ld_ones = 4'd9;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", {lo_tens, lo_ones, lo_err}, 9'h000);
      tick(1);
      rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
      tick(3);
      check("resume_03", {lo_tens, lo_ones, lo_err}, 9'h006);

      // Full cascade period: 60 x 24 = 1440 edges back to 00/00, one upper co pulse.
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      cnt_en = 1'b1;
      tick(1440);
      cnt_en = 1'b0;
      check("casc_lo_00", {lo_tens, lo_ones}, 8'h00);
      check("casc_hi_00", {hi_tens, hi_ones}, 8'h00);
      check("casc_hi_co_pulses", 16'(hi_co_pulses), 16'd1);

      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
